// File: rtl/dbg_pkg.sv
// Shared FSM state encoding and command byte values for the debug memory bridge.
// Pure declarations: no latency, no backpressure.
package dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG,
        ST_MEM,
        ST_TX,
        ST_BURST
    } state_t;

    localparam logic [7:0] CMD_INFO    = 8'h69;  // "i"
    localparam logic [7:0] CMD_ADDR    = 8'h61;  // "a"
    localparam logic [7:0] CMD_WR_BYTE = 8'h77;  // "w"
    localparam logic [7:0] CMD_WR_WORD = 8'h57;  // "W"
    localparam logic [7:0] CMD_RD      = 8'h72;  // "r"
    localparam logic [7:0] CMD_BURST   = 8'h52;  // "R"
    localparam logic [7:0] CMD_LATCH   = 8'h6C;  // "l"

endpackage

// File: rtl/dbg_lane_mux.sv
// Big-endian byte-lane select: lane 0 is the most significant byte of the word.
// Purely combinational, zero latency, no backpressure.
module dbg_lane_mux #(
    parameter int DW = 16,
    parameter int LW = 1
) (
    input  logic [DW-1:0] word,
    input  logic [LW-1:0] lane,
    output logic [7:0]    lane_byte
);

    localparam int NB = DW / 8;

    always_comb begin
        lane_byte = '0;
        for (int k = 0; k < NB; k++) begin
            if (int'(lane) == k) begin
                lane_byte = word[DW-1-8*k -: 8];
            end
        end
    end

endmodule

// File: rtl/dbg_mem_bridge.sv
// UART byte-command bridge to a single-port memory; mem_cs rises the cycle after the last argument byte, tx byte the cycle after mem_ack.
// Backpressure: tx byte held until tx_ready; rx bytes arriving outside IDLE/ARG are dropped and flagged in sticky overrun.
module dbg_mem_bridge
    import dbg_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [7:0]    tx_data,
    output logic          mem_cs,
    output logic          mem_re,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    input  logic [7:0]    status,
    output logic          overrun,
    output logic          busy
);

    localparam int NB = DW / 8;
    localparam int AB = AW / 8;
    localparam int LB = (NB > 1) ? $clog2(NB) : 0;
    localparam int LW = (LB > 0) ? LB : 1;

    state_t          state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [2:0]      arg_cnt_q, arg_cnt_d;
    logic [DW-1:0]   word_q, word_d;
    logic [8:0]      count_q, count_d;
    logic [LW-1:0]   bidx_q, bidx_d;
    logic            tx_valid_d;
    logic [7:0]      tx_data_d;
    logic            cs_d, re_d;
    logic [NB-1:0]   be_d;
    logic [AW-1:0]   addr_d;
    logic [DW-1:0]   wdata_d;
    logic            overrun_d;

    logic [LW-1:0]   addr_lane;
    logic [NB-1:0]   lane_be;
    logic [DW-1:0]   mux_word;
    logic [LW-1:0]   mux_lane;
    logic [7:0]      lane_byte;

    assign addr_lane = mem_addr[LW-1:0] & LW'(NB - 1);
    assign lane_be   = NB'(1) << (NB - 1 - int'(addr_lane));
    // A single read forwards the arriving word; everything else selects from the latched word.
    assign mux_word  = (state_q == ST_MEM) ? mem_rdata : word_q;
    assign mux_lane  = (state_q == ST_BURST) ? bidx_q : addr_lane;
    assign busy      = (state_q != ST_IDLE);

    dbg_lane_mux #(
        .DW (DW),
        .LW (LW)
    ) u_lane_mux (
        .word      (mux_word),
        .lane      (mux_lane),
        .lane_byte (lane_byte)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        arg_cnt_d  = arg_cnt_q;
        word_d     = word_q;
        count_d    = count_q;
        bidx_d     = bidx_q;
        tx_valid_d = tx_valid;
        tx_data_d  = tx_data;
        cs_d       = mem_cs;
        re_d       = mem_re;
        be_d       = mem_be;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
        overrun_d  = overrun;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    cmd_d = rx_data;
                    case (rx_data)
                        CMD_INFO: begin
                            tx_data_d  = status;
                            tx_valid_d = 1'b1;
                            state_d    = ST_TX;
                        end
                        CMD_ADDR: begin
                            arg_cnt_d = 3'(AB - 1);
                            state_d   = ST_ARG;
                        end
                        CMD_WR_BYTE, CMD_BURST: begin
                            arg_cnt_d = '0;
                            state_d   = ST_ARG;
                        end
                        CMD_WR_WORD: begin
                            arg_cnt_d = 3'(NB - 1);
                            state_d   = ST_ARG;
                        end
                        CMD_RD: begin
                            cs_d    = 1'b1;
                            re_d    = 1'b1;
                            be_d    = '0;
                            state_d = ST_MEM;
                        end
                        CMD_LATCH: begin
                            tx_data_d  = lane_byte;
                            tx_valid_d = 1'b1;
                            addr_d     = mem_addr + AW'(1);
                            state_d    = ST_TX;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ARG: begin
                if (rx_valid) begin
                    arg_cnt_d = arg_cnt_q - 3'd1;
                    case (cmd_q)
                        CMD_ADDR:    addr_d = (mem_addr << 8) | AW'(rx_data);
                        CMD_WR_BYTE: begin
                            wdata_d = {NB{rx_data}};
                            be_d    = lane_be;
                        end
                        CMD_WR_WORD: begin
                            wdata_d = (mem_wdata << 8) | DW'(rx_data);
                            be_d    = '1;
                        end
                        default:     count_d = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    endcase
                    if (arg_cnt_q == '0) begin
                        if (cmd_q == CMD_ADDR) begin
                            state_d = ST_IDLE;
                        end else begin
                            cs_d    = 1'b1;
                            re_d    = (cmd_q == CMD_BURST);
                            bidx_d  = '0;
                            state_d = ST_MEM;
                            if (cmd_q == CMD_BURST) begin
                                be_d = '0;
                            end
                        end
                    end
                end
            end
            ST_MEM: begin
                if (rx_valid) begin
                    overrun_d = 1'b1;
                end
                if (mem_ack) begin
                    cs_d = 1'b0;
                    re_d = 1'b0;
                    be_d = '0;
                    case (cmd_q)
                        CMD_WR_BYTE: begin
                            addr_d  = mem_addr + AW'(1);
                            state_d = ST_IDLE;
                        end
                        CMD_WR_WORD: begin
                            addr_d  = mem_addr + AW'(NB);
                            state_d = ST_IDLE;
                        end
                        CMD_RD: begin
                            word_d     = mem_rdata;
                            tx_data_d  = lane_byte;
                            tx_valid_d = 1'b1;
                            addr_d     = mem_addr + AW'(1);
                            state_d    = ST_TX;
                        end
                        default: begin
                            word_d  = mem_rdata;
                            addr_d  = mem_addr + AW'(NB);
                            bidx_d  = '0;
                            state_d = ST_BURST;
                        end
                    endcase
                end
            end
            ST_TX: begin
                if (rx_valid) begin
                    overrun_d = 1'b1;
                end
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    // A drop in the acceptance cycle must survive the status read-out.
                    if (cmd_q == CMD_INFO && !rx_valid) begin
                        overrun_d = 1'b0;
                    end
                    if (cmd_q == CMD_BURST) begin
                        if (bidx_q == LW'(NB - 1)) begin
                            count_d = count_q - 9'd1;
                            if (count_q == 9'd1) begin
                                state_d = ST_IDLE;
                            end else begin
                                cs_d    = 1'b1;
                                re_d    = 1'b1;
                                be_d    = '0;
                                bidx_d  = '0;
                                state_d = ST_MEM;
                            end
                        end else begin
                            bidx_d  = bidx_q + LW'(1);
                            state_d = ST_BURST;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BURST: begin
                if (rx_valid) begin
                    overrun_d = 1'b1;
                end
                tx_data_d  = lane_byte;
                tx_valid_d = 1'b1;
                state_d    = ST_TX;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            arg_cnt_q <= '0;
            word_q    <= '0;
            count_q   <= '0;
            bidx_q    <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            mem_cs    <= 1'b0;
            mem_re    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            arg_cnt_q <= arg_cnt_d;
            word_q    <= word_d;
            count_q   <= count_d;
            bidx_q    <= bidx_d;
            tx_valid  <= tx_valid_d;
            tx_data   <= tx_data_d;
            mem_cs    <= cs_d;
            mem_re    <= re_d;
            mem_be    <= be_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            overrun   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_dbg_mem_bridge.sv
// Scoreboard bench for dbg_mem_bridge: expected memory accesses and tx bytes are queued as commands are sent.
// The memory responder and tx sink pop and compare as the DUT produces them.
module tb_dbg_mem_bridge;

    localparam logic [7:0] C_I  = "i";
    localparam logic [7:0] C_A  = "a";
    localparam logic [7:0] C_W  = "w";
    localparam logic [7:0] C_WW = "W";
    localparam logic [7:0] C_R  = "r";
    localparam logic [7:0] C_RR = "R";
    localparam logic [7:0] C_L  = "l";

    typedef struct {
        logic [15:0] addr;
        logic [1:0]  be;
        logic        re;
        logic [15:0] wdata;
    } mem_exp_t;

    logic        clk;
    logic        nreset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        mem_cs;
    logic        mem_re;
    logic [1:0]  mem_be;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [7:0]  status;
    logic        overrun;
    logic        busy;

    mem_exp_t    mem_exp_q[$];
    logic [15:0] rdata_q[$];
    logic [7:0]  tx_exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ready_after = 0;
    int ack_delay   = 1;
    int n_mem_acc   = 0;
    bit rand_ready  = 1'b1;

    dbg_mem_bridge #(
        .AW (16),
        .DW (16)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .mem_cs    (mem_cs),
        .mem_re    (mem_re),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .status    (status),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk_eq("idle_timeout", busy, 0);
    endtask

    task automatic exp_mem(input logic [15:0] a, input logic [1:0] be, input logic re,
                           input logic [15:0] wd);
        mem_exp_t e;
        e.addr  = a;
        e.be    = be;
        e.re    = re;
        e.wdata = wd;
        mem_exp_q.push_back(e);
    endtask

    // Memory responder: checks each access as mem_cs rises, acks after ack_delay cycles.
    initial begin
        bit          in_acc;
        int          wait_cnt;
        logic [15:0] acc_addr;
        mem_exp_t    e;
        in_acc    = 1'b0;
        wait_cnt  = 0;
        acc_addr  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!nreset) begin
                mem_ack = 1'b0;
                in_acc  = 1'b0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else begin
                if (mem_cs && !in_acc) begin
                    in_acc   = 1'b1;
                    wait_cnt = ack_delay;
                    acc_addr = mem_addr;
                    n_mem_acc++;
                    if (mem_exp_q.size() == 0) begin
                        chk_eq("mem_unexp", mem_exp_q.size(), 1);
                    end else begin
                        e = mem_exp_q.pop_front();
                        chk_eq("mem_addr", mem_addr, e.addr);
                        chk_eq("mem_be", mem_be, e.be);
                        chk_eq("mem_re", mem_re, e.re);
                        if (!e.re) chk_eq("mem_wdata", mem_wdata, e.wdata);
                    end
                end
                if (in_acc) begin
                    if (wait_cnt == 0) begin
                        chk_eq("mem_addr_hold", mem_addr, acc_addr);
                        if (mem_re) mem_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : 16'hDEAD;
                        mem_ack = 1'b1;
                        in_acc  = 1'b0;
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    // Tx sink: drives tx_ready and compares every accepted byte.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            tx_ready = (cyc >= ready_after) && (!rand_ready || $urandom_range(0, 1) == 1);
            if (nreset && tx_valid && tx_ready) begin
                if (tx_exp_q.size() == 0) chk_eq("tx_unexp", tx_exp_q.size(), 1);
                else chk_eq("tx_data", tx_data, tx_exp_q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        nreset   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        status   = '0;
        repeat (3) @(negedge clk);
        chk_eq("rst_tx_valid", tx_valid, 0);
        chk_eq("rst_tx_data", tx_data, 0);
        chk_eq("rst_mem_cs", mem_cs, 0);
        chk_eq("rst_mem_be", mem_be, 0);
        chk_eq("rst_mem_addr", mem_addr, 0);
        chk_eq("rst_overrun", overrun, 0);
        chk_eq("rst_busy", busy, 0);
        nreset = 1'b1;

        // Word write
        exp_mem(16'h1234, 2'b11, 1'b0, 16'hABCD);
        send_rx(C_A); send_rx(8'h12); send_rx(8'h34);
        send_rx(C_WW); send_rx(8'hAB); send_rx(8'hCD);
        wait_idle();
        chk_eq("W_addr_after", mem_addr, 16'h1236);

        // Byte write to odd (low) lane
        exp_mem(16'h0005, 2'b01, 1'b0, 16'h5A5A);
        send_rx(C_A); send_rx(8'h00); send_rx(8'h05);
        send_rx(C_W); send_rx(8'h5A);
        wait_idle();
        chk_eq("w_addr_after", mem_addr, 16'h0006);

        // Single read then latched read without a second access
        exp_mem(16'h2000, 2'b00, 1'b1, 16'h0000);
        rdata_q.push_back(16'hBEEF);
        tx_exp_q.push_back(8'hBE);
        tx_exp_q.push_back(8'hEF);
        acc0 = n_mem_acc;
        send_rx(C_A); send_rx(8'h20); send_rx(8'h00);
        send_rx(C_R);
        wait_idle();
        send_rx(C_L);
        wait_idle();
        chk_eq("rl_addr_after", mem_addr, 16'h2002);
        chk_eq("rl_access_cnt", n_mem_acc - acc0, 1);

        // Burst read wrapping past the top of the address space
        exp_mem(16'hFFFE, 2'b00, 1'b1, 16'h0000);
        exp_mem(16'h0000, 2'b00, 1'b1, 16'h0000);
        rdata_q.push_back(16'h1111);
        rdata_q.push_back(16'h2222);
        tx_exp_q.push_back(8'h11); tx_exp_q.push_back(8'h11);
        tx_exp_q.push_back(8'h22); tx_exp_q.push_back(8'h22);
        send_rx(C_A); send_rx(8'hFF); send_rx(8'hFE);
        send_rx(C_RR); send_rx(8'h02);
        wait_idle();
        chk_eq("R_addr_after", mem_addr, 16'h0002);

        // Slow ack with a byte arriving mid-access, then status read clears overrun
        ack_delay = 5;
        exp_mem(16'h0010, 2'b00, 1'b1, 16'h0000);
        rdata_q.push_back(16'h1234);
        tx_exp_q.push_back(8'h12);
        send_rx(C_A); send_rx(8'h00); send_rx(8'h10);
        send_rx(C_R);
        send_rx(8'h55);
        wait_idle();
        ack_delay = 1;
        chk_eq("ovr_set", overrun, 1);
        status = 8'h42;
        tx_exp_q.push_back(8'h42);
        send_rx(C_I);
        wait_idle();
        chk_eq("ovr_clear", overrun, 0);

        // Drop in the same cycle the status byte is accepted keeps overrun
        rand_ready  = 1'b0;
        status      = 8'h77;
        tx_exp_q.push_back(8'h77);
        ready_after = cyc + 1000;
        send_rx(C_I);
        @(negedge clk);
        rx_valid    = 1'b1;
        rx_data     = 8'h33;
        ready_after = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
        wait_idle();
        chk_eq("ovr_same_cycle", overrun, 1);

        // Held tx byte stays stable, then reset abandons it
        status      = 8'h5C;
        ready_after = cyc + 1000;
        send_rx(C_I);
        status = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_eq("hold_tx_valid", tx_valid, 1);
            chk_eq("hold_tx_data", tx_data, 8'h5C);
        end
        nreset = 1'b0;
        @(negedge clk);
        chk_eq("mid_rst_tx_valid", tx_valid, 0);
        chk_eq("mid_rst_tx_data", tx_data, 0);
        chk_eq("mid_rst_busy", busy, 0);
        chk_eq("mid_rst_mem_addr", mem_addr, 0);
        chk_eq("mid_rst_overrun", overrun, 0);
        chk_eq("mid_rst_mem_cs", mem_cs, 0);
        nreset      = 1'b1;
        ready_after = 0;
        repeat (3) @(negedge clk);

        chk_eq("mem_exp_left", mem_exp_q.size(), 0);
        chk_eq("tx_exp_left", tx_exp_q.size(), 0);
        chk_eq("rdata_left", rdata_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
